// File: rtl/cla_pkg.sv
// Shared types and constants for the digit-serial carry-lookahead adder.
// Optional signed-overflow output is enabled by defining CLA_SERIAL_OVF_EN.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/cla_nibble_add.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder slice.
module cla_nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is flattened from g/p and ci so no carry ripples through the slice.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s  = p_s ^ c_s[3:0];
    assign co = c_s[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial WIDTH-bit adder: one nibble per clock through a single CLA slice.
// Define CLA_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               out_valid_q, out_valid_d;
    logic [NIB_W-1:0]   slice_a_s;
    logic [NIB_W-1:0]   slice_b_s;
    logic [NIB_W-1:0]   slice_s_s;
    logic               slice_co_s;
    logic               last_s;

    assign slice_a_s = a_q[NIB_W*idx_q +: NIB_W];
    assign slice_b_s = b_q[NIB_W*idx_q +: NIB_W];
    assign last_s    = (idx_q == IDX_W'(NIB - 1));

    cla_nibble_add u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_q),
        .s  (slice_s_s),
        .co (slice_co_s)
    );

`ifdef CLA_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
    logic c_msb_s;

    // Carry into the MSB is recovered from the slice sum bit and its operand bits.
    assign c_msb_s = slice_s_s[NIB_W-1] ^ slice_a_s[NIB_W-1] ^ slice_b_s[NIB_W-1];

    // Overflow register: loaded on the final nibble, held otherwise.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == RUN) && last_s) begin
            ovf_d = c_msb_s ^ slice_co_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[NIB_W*idx_q +: NIB_W] = slice_s_s;
                carry_d = slice_co_s;
                if (last_s) begin
                    idx_d       = {IDX_W{1'b0}};
                    cout_d      = slice_co_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Controller, operand, carry and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder (WIDTH=16); checks ovf when CLA_SERIAL_OVF_EN is defined.
module tb_cla_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_SERIAL_OVF_EN
    logic        ovf;
`endif

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the result handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_sum", {16'd0, sum}, {16'd0, e.sum});
                check("result_cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef CLA_SERIAL_OVF_EN
                check("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input int hold, input bit toggle);
        int guard;
        exp_t e;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        e.sum = es; e.cout = ec; e.ovf = eo;
        sb_q.push_back(e);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (toggle) begin
                a = 16'($urandom);
                b = 16'($urandom);
                cin = ~cin;
                in_valid = (c < 4);
            end
            @(posedge clk); #1;
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            check("out_valid_latency", {31'd0, out_valid}, (c == 4) ? 32'd1 : 32'd0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {16'd0, sum}, {16'd0, es});
            check("hold_cout", {31'd0, cout}, {31'd0, ec});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sum", {16'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
`ifdef CLA_SERIAL_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 2, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 10, 1'b0);

        // Abort an operation during its second RUN cycle.
        a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

        do_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
